// File: rtl/mtxt_pkg.sv
// rtl/mtxt_pkg.sv - shared types and constants for the monochrome text console
package mtxt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLR_LINE,
        ST_CLR_ALL
    } state_t;

    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_SPACE    = 8'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    localparam int ADDR_W = 16;
    localparam int COL_W  = 7;

endpackage

// File: rtl/mtxt_clr_seq.sv
// rtl/mtxt_clr_seq.sv - line/column sweep counter for single-line and full-screen clears
module mtxt_clr_seq
    import mtxt_pkg::*;
#(
    parameter int unsigned COLS  = 80,
    parameter int unsigned LINES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_all,
    input  logic [7:0]       base_line,
    output logic [7:0]       line,
    output logic [COL_W-1:0] col,
    output logic             active,
    output logic             done
);

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
    localparam logic [7:0]       LAST_LINE = 8'(LINES - 1);

    logic all_q;

    // done marks the final cell of the sweep, while it is being written
    assign done = active && (col == LAST_COL) && (!all_q || (line == LAST_LINE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line   <= '0;
            col    <= '0;
            active <= 1'b0;
            all_q  <= 1'b0;
        end else if (start) begin
            line   <= mode_all ? 8'd0 : base_line;
            col    <= '0;
            active <= 1'b1;
            all_q  <= mode_all;
        end else if (active) begin
            if (col == LAST_COL) begin
                col <= '0;
                if (done) begin
                    active <= 1'b0;
                end else begin
                    line <= line + 8'd1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mtxt_console.sv
// rtl/mtxt_console.sv - byte-stream console engine writing the text-mode character RAM
module mtxt_console
    import mtxt_pkg::*;
#(
    parameter int unsigned COLS  = 80,
    parameter int unsigned LINES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        y_reg,
    output logic [COL_W-1:0]  cur_col,
    output logic              busy
);

    localparam logic [7:0] COLS_B = 8'(COLS);

    state_t                   state, state_n;
    logic [7:0]               y_q, y_n;
    logic [COL_W-1:0]         col_q, col_n;
    logic                     bs_q, bs_n;
    logic [7+COL_W:0]         waddr_q, waddr_n;
    logic [7:0]               data_q, data_n;
    logic                     in_ready_q, wr_en_q, busy_q;

    logic                     seq_start, seq_all, seq_active, seq_done;
    logic [7:0]               seq_base, seq_line;
    logic [COL_W-1:0]         seq_col;

    mtxt_clr_seq #(.COLS(COLS), .LINES(LINES)) u_clr_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (seq_start),
        .mode_all  (seq_all),
        .base_line (seq_base),
        .line      (seq_line),
        .col       (seq_col),
        .active    (seq_active),
        .done      (seq_done)
    );

    always_comb begin
        state_n   = state;
        y_n       = y_q;
        col_n     = col_q;
        bs_n      = bs_q;
        waddr_n   = waddr_q;
        data_n    = data_q;
        seq_start = 1'b0;
        seq_all   = 1'b0;
        seq_base  = y_q;
        unique case (state)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (in_data >= CH_PRINT_LO && in_data <= CH_PRINT_HI) begin
                        state_n = ST_WRITE;
                        bs_n    = 1'b0;
                        waddr_n = {y_q, col_q};
                        data_n  = in_data;
                    end else if (in_data == CH_CR) begin
                        col_n = '0;
                    end else if (in_data == CH_LF) begin
                        col_n     = '0;
                        y_n       = y_q + 8'd1;
                        seq_start = 1'b1;
                        seq_base  = y_q + 8'd1;
                        data_n    = CH_SPACE;
                        state_n   = ST_CLR_LINE;
                    end else if (in_data == CH_BS && col_q != '0) begin
                        col_n   = col_q - 1'b1;
                        waddr_n = {y_q, col_q - 1'b1};
                        data_n  = CH_SPACE;
                        bs_n    = 1'b1;
                        state_n = ST_WRITE;
                    end else if (in_data == CH_FF) begin
                        y_n       = '0;
                        col_n     = '0;
                        seq_start = 1'b1;
                        seq_all   = 1'b1;
                        data_n    = CH_SPACE;
                        state_n   = ST_CLR_ALL;
                    end
                end
            end
            ST_WRITE: begin
                if (bs_q) begin
                    state_n = ST_IDLE;
                end else if (({1'b0, col_q} + 8'd1) == COLS_B) begin
                    // end-of-line wrap behaves exactly like a line feed
                    col_n     = '0;
                    y_n       = y_q + 8'd1;
                    seq_start = 1'b1;
                    seq_base  = y_q + 8'd1;
                    data_n    = CH_SPACE;
                    state_n   = ST_CLR_LINE;
                end else begin
                    col_n   = col_q + 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_CLR_LINE, ST_CLR_ALL: begin
                if (seq_done) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            y_q        <= '0;
            col_q      <= '0;
            bs_q       <= 1'b0;
            waddr_q    <= '0;
            data_q     <= '0;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_n;
            y_q        <= y_n;
            col_q      <= col_n;
            bs_q       <= bs_n;
            waddr_q    <= waddr_n;
            data_q     <= data_n;
            in_ready_q <= (state_n == ST_IDLE);
            wr_en_q    <= (state_n != ST_IDLE);
            busy_q     <= (state_n != ST_IDLE);
        end
    end

    // during a sweep the address comes straight from the sweep counter flops
    assign wr_addr  = {1'b0, seq_active ? {seq_line, seq_col} : waddr_q};
    assign wr_data  = data_q;
    assign wr_en    = wr_en_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign y_reg    = y_q;
    assign cur_col  = col_q;

endmodule

// File: tb/tb_mtxt_console.sv
// tb/tb_mtxt_console.sv - self-checking bench for mtxt_console against a screen-level model
module tb_mtxt_console;

    localparam int COLS  = 80;
    localparam int LINES = 256;
    localparam int LIMIT = LINES * COLS + 20;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  y_reg;
    logic [6:0]  cur_col;
    logic        busy;

    int tests = 0;
    int fails = 0;

    int obs_q[$];
    int exp_q[$];
    int my_y = 0;
    int my_col = 0;

    mtxt_console #(.COLS(COLS), .LINES(LINES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .y_reg    (y_reg),
        .cur_col  (cur_col),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (wr_en === 1'b1) obs_q.push_back(int'(wr_addr) * 256 + int'(wr_data));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_line_clear(input int line);
        for (int c = 0; c < COLS; c++) exp_q.push_back((line * 128 + c) * 256 + 32);
    endtask

    task automatic model_step(input logic [7:0] b, output int lat);
        lat = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back((my_y * 128 + my_col) * 256 + int'(b));
            my_col++;
            lat = 1;
            if (my_col == COLS) begin
                my_col = 0;
                my_y = (my_y + 1) % LINES;
                push_line_clear(my_y);
                lat = 1 + COLS;
            end
        end else if (b == 8'h0D) begin
            my_col = 0;
        end else if (b == 8'h0A) begin
            my_col = 0;
            my_y = (my_y + 1) % LINES;
            push_line_clear(my_y);
            lat = COLS;
        end else if (b == 8'h08) begin
            if (my_col > 0) begin
                my_col--;
                exp_q.push_back((my_y * 128 + my_col) * 256 + 32);
                lat = 1;
            end
        end else if (b == 8'h0C) begin
            my_y = 0;
            my_col = 0;
            for (int l = 0; l < LINES; l++) push_line_clear(l);
            lat = LINES * COLS;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int lat, exp_lat, n, busy_bad;
        model_step(b, exp_lat);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        busy_bad = 0;
        while (in_ready !== 1'b1 && lat < LIMIT) begin
            if (busy !== 1'b1) busy_bad++;
            lat++;
            @(posedge clk);
            #1;
        end
        check("ready_low_cycles", lat, exp_lat);
        check("busy_while_active", busy_bad, 0);
        check("busy_after", busy, 1'b0);
        check("write_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("write_addr_data", obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
        check("y_reg", y_reg, my_y);
        check("cur_col", cur_col, my_col);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #3;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, 16'h0000);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_y_reg", y_reg, 8'h00);
        check("rst_cur_col", cur_col, 7'h00);
        check("rst_busy", busy, 1'b0);
        #19 rst = 1'b0;
        @(posedge clk);
        #1;

        send(8'h41);
        send(8'h0D);
        for (int i = 0; i < COLS; i++) send(8'h42);

        for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)));
        send(8'h08);
        send(8'h0D);
        send(8'h08);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 78) b = 8'h0D;
            else if (r < 84) b = 8'h0A;
            else if (r < 94) b = 8'h08;
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h0C) b = 8'h7F;
            end
            send(b);
        end

        send(8'h0C);

        for (int i = 0; i < LINES; i++) send(8'h0A);
        for (int i = 0; i < 3; i++) send(8'($urandom_range(32, 126)));

        in_data  = 8'h0A;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_clear_wr_en", wr_en, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_wr_en", wr_en, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_y_reg", y_reg, 8'h00);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_y_reg", y_reg, 8'h00);
        check("post_rst_cur_col", cur_col, 7'h00);
        obs_q.delete();
        exp_q.delete();
        my_y = 0;
        my_col = 0;
        send(8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
